pio_counter_bank: RTL and testbench

//  Three-channel programmable down-counter bank fed directly by the PIO output register.
//  The PIO's 2-bit counter_set field selects the target channel; a bus write then loads a value or a control word.

---
 rtl/pio_pkg.sv | 19 +
 rtl/pio_counter_bank_if.sv | 23 ++
 rtl/pio_counter_chan.sv | 58 +++++
 rtl/pio_counter_bank.sv | 67 ++++++
 tb/tb_pio_counter_bank.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the PIO-driven counter bank: channel selects, control
// word layout and channel modes.
package pio_pkg;

   localparam int NUM_CH = 3;

   localparam logic [1:0] CSEL_CH0  = 2'd0;
   localparam logic [1:0] CSEL_CH1  = 2'd1;
   localparam logic [1:0] CSEL_CH2  = 2'd2;
   localparam logic [1:0] CSEL_CTRL = 2'd3;

   localparam int CTRL_EN_LSB   = 0;
   localparam int CTRL_MODE_LSB = 3;
   localparam int CTRL_CLR_LSB  = 6;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/pio_counter_bank_if.sv
// PIO-side bus into the counter bank: select/strobe/data and tick enables in,
// read-back and terminal-count flags out.
interface pio_counter_bank_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       counter_set;
   logic             counter_we;
   logic [WIDTH-1:0] counter_val;
   logic [2:0]       tick;
   logic [WIDTH-1:0] counter_out;
   logic [2:0]       tc_pulse;
   logic [2:0]       tc_done;

   modport master (
      output counter_set, counter_we, counter_val, tick,
      input  counter_out, tc_pulse, tc_done
   );

   modport slave (
      input  counter_set, counter_we, counter_val, tick,
      output counter_out, tc_pulse, tc_done
   );
endinterface

// File: rtl/pio_counter_chan.sv
// One down-counter channel: count and reload registers, terminal-count pulse
// and sticky done flag.
module pio_counter_chan
   import pio_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             tick,
   input  logic             we,
   input  logic             clr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] count,
   output logic             tc_pulse,
   output logic             tc_done
);

   logic [WIDTH-1:0] reload;
   logic             live;
   logic             hit;

   // A write on this channel swallows any tick in the same cycle.
   assign live = en && tick && !we && (count != '0);
   assign hit  = live && (count == WIDTH'(1));

   // NOTE: reset is synchronous, so rst is tested inside the clocked block and stays out of the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         reload   <= '0;
         tc_pulse <= 1'b0;
         tc_done  <= 1'b0;
      end else begin
         tc_pulse <= hit;

         if (we) begin
            reload <= wdata;
            count  <= wdata;
         end else if (hit) begin
            unique case (mode)
               MODE_RELOAD:  count <= reload;
               MODE_ONESHOT: count <= '0;
            endcase
         end else if (live) begin
            count <= count - WIDTH'(1);
         end

         // A fresh terminal count beats a same-cycle W1C.
         if (we)       tc_done <= 1'b0;
         else if (hit) tc_done <= 1'b1;
         else if (clr) tc_done <= 1'b0;
      end
   end

endmodule

// File: rtl/pio_counter_bank.sv
// Three-channel programmable down-counter bank: write decode, control register
// and registered read-back mux around three channel instances.
module pio_counter_bank
   import pio_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   pio_counter_bank_if.slave bus
);

   logic [NUM_CH-1:0] we_ch;
   logic              ctrl_we;
   logic [NUM_CH-1:0] clr;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] pulse;
   logic [NUM_CH-1:0] done;
   logic [WIDTH-1:0]  count [NUM_CH];

   assign we_ch[0] = bus.counter_we && (bus.counter_set == CSEL_CH0);
   assign we_ch[1] = bus.counter_we && (bus.counter_set == CSEL_CH1);
   assign we_ch[2] = bus.counter_we && (bus.counter_set == CSEL_CH2);
   assign ctrl_we  = bus.counter_we && (bus.counter_set == CSEL_CTRL);
   assign clr      = ctrl_we ? bus.counter_val[CTRL_CLR_LSB +: NUM_CH] : '0;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      pio_counter_chan #(.WIDTH(WIDTH)) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en       (en[i]),
         .mode     (mode[i]),
         .tick     (bus.tick[i]),
         .we       (we_ch[i]),
         .clr      (clr[i]),
         .wdata    (bus.counter_val),
         .count    (count[i]),
         .tc_pulse (pulse[i]),
         .tc_done  (done[i])
      );
   end

   assign bus.tc_pulse = pulse;
   assign bus.tc_done  = done;

   always_ff @(posedge clk) begin
      if (rst) begin
         en              <= '0;
         mode            <= '0;
         bus.counter_out <= '0;
      end else begin
         if (ctrl_we) begin
            en   <= bus.counter_val[CTRL_EN_LSB   +: NUM_CH];
            mode <= bus.counter_val[CTRL_MODE_LSB +: NUM_CH];
         end

         unique case (bus.counter_set)
            CSEL_CH0:  bus.counter_out <= count[0];
            CSEL_CH1:  bus.counter_out <= count[1];
            CSEL_CH2:  bus.counter_out <= count[2];
            CSEL_CTRL: bus.counter_out <= WIDTH'({done, mode, en});
         endcase
      end
   end

endmodule

// File: tb/tb_pio_counter_bank.sv
// Directed scenarios plus randomized traffic against a cycle-level model of the
// counter bank's rules.
module tb_pio_counter_bank;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   pio_counter_bank_if #(.WIDTH(W)) bus ();

   pio_counter_bank #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference state
   logic [W-1:0] m_cnt [3];
   logic [W-1:0] m_rel [3];
   logic [2:0]   m_en, m_mode, m_done, m_pulse;
   logic [W-1:0] m_out;

   task automatic drive(input logic r, input logic we, input logic [1:0] set,
                        input logic [W-1:0] val, input logic [2:0] tk);
      rst             = r;
      bus.counter_we  = we;
      bus.counter_set = set;
      bus.counter_val = val;
      bus.tick        = tk;
   endtask

   // Advance one clock: predict from the inputs, clock the DUT, compare.
   task automatic step();
      logic [W-1:0] n_cnt [3];
      logic [2:0]   n_done, n_pulse;
      logic [W-1:0] n_out;
      int           sel;
      sel     = int'(bus.counter_set);
      n_pulse = 3'b000;
      n_done  = m_done;
      n_out   = (sel == 3) ? W'({m_done, m_mode, m_en}) : m_cnt[sel];
      for (int i = 0; i < 3; i++) begin
         n_cnt[i] = m_cnt[i];
         if (bus.counter_we && sel == i) begin
            n_cnt[i]  = bus.counter_val;
            m_rel[i]  = bus.counter_val;
            n_done[i] = 1'b0;
         end else if (m_en[i] && bus.tick[i] && m_cnt[i] > 0) begin
            if (m_cnt[i] == 1) begin
               n_cnt[i]   = m_mode[i] ? m_rel[i] : '0;
               n_pulse[i] = 1'b1;
               n_done[i]  = 1'b1;
            end else begin
               n_cnt[i] = m_cnt[i] - 1;
            end
         end
      end
      if (bus.counter_we && sel == 3) begin
         n_done = n_done & ~(bus.counter_val[8:6] & ~n_pulse);
         m_en   = bus.counter_val[2:0];
         m_mode = bus.counter_val[5:3];
      end
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            n_cnt[i] = '0;
            m_rel[i] = '0;
         end
         m_en = '0; m_mode = '0; n_done = '0; n_pulse = '0; n_out = '0;
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) m_cnt[i] = n_cnt[i];
      m_done  = n_done;
      m_pulse = n_pulse;
      m_out   = n_out;
      #1;
      check("model_out",   bus.counter_out, m_out);
      check("model_pulse", bus.tc_pulse,    m_pulse);
      check("model_done",  bus.tc_done,     m_done);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = '0;
         m_rel[i] = '0;
      end
      m_en = '0; m_mode = '0; m_done = '0; m_pulse = '0; m_out = '0;

      // 1: reset, one-shot countdown on ch0
      drive(1, 0, 0, 0, 3'b000); step();
      check("rst_out",   bus.counter_out, 0);
      check("rst_pulse", bus.tc_pulse,    0);
      check("rst_done",  bus.tc_done,     0);
      drive(0, 1, 0, 3, 3'b000); step();
      drive(0, 1, 3, 1, 3'b000); step();
      for (int k = 1; k <= 5; k++) begin
         drive(0, 0, 0, 0, 3'b001); step();
         if (k == 1) check("t1_out_first", bus.counter_out, 3);
         if (k == 3) begin
            check("t1_pulse", bus.tc_pulse, 3'b001);
            check("t1_done",  bus.tc_done,  3'b001);
         end
         if (k >= 4) begin
            check("t1_pulse_off", bus.tc_pulse,    0);
            check("t1_hold",      bus.counter_out, 0);
         end
      end

      // 2: auto-reload on ch1 with tick held high
      drive(0, 1, 1, 2, 3'b000); step();
      drive(0, 1, 3, (2 << 3) | 2, 3'b000); step();
      for (int k = 1; k <= 6; k++) begin
         drive(0, 0, 1, 0, 3'b010); step();
         check("t2_pulse", bus.tc_pulse[1], (k % 2) == 0);
      end

      // 5: status read-back
      drive(0, 0, 3, 0, 3'b000); step();
      check("t5_status", bus.counter_out, (3 << 6) | (2 << 3) | 2);

      // 3: write beats tick on ch2 at count 1
      drive(0, 1, 2, 1, 3'b000); step();
      drive(0, 1, 3, 4, 3'b000); step();
      drive(0, 1, 2, 5, 3'b100); step();
      check("t3_pulse", bus.tc_pulse[2], 0);
      check("t3_done",  bus.tc_done[2],  0);
      drive(0, 0, 2, 0, 3'b000); step();
      check("t3_count", bus.counter_out, 5);

      // 4: W1C colliding with a new terminal count on ch0
      drive(0, 1, 0, 2, 3'b000); step();
      drive(0, 1, 3, 1, 3'b000); step();
      drive(0, 0, 0, 0, 3'b001); step();
      drive(0, 1, 3, (1 << 6) | 1, 3'b001); step();
      check("t4_pulse",    bus.tc_pulse[0], 1);
      check("t4_set_wins", bus.tc_done[0],  1);
      drive(0, 1, 3, (1 << 6) | 1, 3'b000); step();
      check("t4_cleared",  bus.tc_done[0],  0);

      // 6: reset mid-count on ch1
      drive(0, 1, 1, 7, 3'b000); step();
      drive(0, 1, 3, 2, 3'b000); step();
      drive(0, 0, 1, 0, 3'b010); step();
      drive(1, 0, 1, 0, 3'b111); step();
      check("t6_out",   bus.counter_out, 0);
      check("t6_pulse", bus.tc_pulse,    0);
      check("t6_done",  bus.tc_done,     0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 0, 3'b111); step();
         check("t6_idle_out",   bus.counter_out, 0);
         check("t6_idle_pulse", bus.tc_pulse,    0);
      end

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         logic         r, we;
         logic [1:0]   set;
         logic [W-1:0] val;
         r   = ($urandom_range(0, 199) == 0);
         we  = ($urandom_range(0, 3) == 0);
         set = 2'($urandom_range(0, 3));
         if (set == 2'd3)                      val = W'($urandom_range(0, 511));
         else if ($urandom_range(0, 7) == 0)   val = $urandom;
         else                                  val = W'($urandom_range(0, 5));
         drive(r, we, set, val, 3'($urandom_range(0, 7)));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
